ulpi_reg_init: RTL
==================

// Module: ulpi_reg_init
// PURPOSE
// Drives the register-access port of ulpi_wrapper in the PHY clock domain (CLK_60M).
// After reset it performs the following sequence:
//   - checks the PHY ID;
//   - programs Function Control, Interface Control and OTG Control;
//   - reads each of them back.
// It then serves single register read/write commands from the function controller until the next reset.
// PARAMETERS
// STARTUP_DLY   16'd6000   cycles after reset before first access (100us @60MHz)
// ACK_TIMEOUT   8'd255     max cycles from strobe to reg_ack_i
// VID_EXP       16'h0424   expected vendor ID {reg0x01,reg0x00}
// PID_EXP       16'h0006   expected product ID {reg0x03,reg0x02}
// FUNC_CTRL_VAL 8'h45      written to 0x04 (XcvrSel=01, TermSel=1, OpMode=00, SuspendM=1)
// IFC_CTRL_VAL  8'h00      written to 0x07
// OTG_CTRL_VAL  8'h00      written to 0x0A (DP/DM pulldowns off)
// PORTS
// clk_i        in   1   ULPI 60MHz clock
// rst_i        in   1   async reset, active high
// reg_addr_o   out  8   to ulpi_wrapper reg_addr_i
// reg_stb_o    out  1   one-cycle access strobe
// reg_we_o     out  1   1=write, 0=read; valid with reg_stb_o
// reg_data_o   out  8   write data
// reg_data_i   in   8   read data, valid with reg_ack_i
// reg_ack_i    in   1   access complete
// cmd_valid_i  in   1   runtime command request
// cmd_ready_o  out  1   command accepted when valid&ready
// cmd_we_i     in   1   runtime write enable
// cmd_addr_i   in   8   runtime register address
// cmd_wdata_i  in   8   runtime write data
// rsp_valid_o  out  1   one-cycle pulse: runtime access finished
// rsp_rdata_o  out  8   read data (0 for writes), held until next rsp
// rsp_err_o    out  1   runtime access timed out; valid with rsp_valid_o
// init_done_o  out  1   init sequence passed (sticky)
// init_err_o   out  1   init sequence failed (sticky until reset)
// err_code_o   out  2   1=ack timeout, 2=ID mismatch, 3=readback mismatch, 0=none
// BEHAVIOUR
// - Reset: all outputs 0, state DELAY, delay counter 0, ID shift register 0.
// - DELAY: count to STARTUP_DLY-1, then go to ID_RD.
// - ID_RD: reads 0x00..0x03 in order. If {r1,r0}!=VID_EXP or {r3,r2}!=PID_EXP, go to ERROR with code 2.
// - CFG_WR: writes 0x04, 0x07, 0x0A with their parameter values.
// - CFG_RD: reads 0x04, 0x07, 0x0A. On the first mismatch, go to ERROR with code 3.
// - CFG_RD all match: init_done_o<=1, go to READY.
// - Access sub-FSM ISSUE->WAIT:
//   - reg_stb_o=1 for exactly 1 cycle in ISSUE; addr/we/data held stable from ISSUE until ack.
//   - An ack sampled in the ISSUE cycle or any WAIT cycle completes the access; read data is captured on that edge.
//   - The next strobe is issued no earlier than 1 cycle after the ack; at most one access outstanding.
//   - The timeout counter clears at ISSUE. Reaching ACK_TIMEOUT with no ack aborts the access:
//     - during init: go to ERROR, code 1;
//     - at runtime: pulse rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=0.
// - reg_ack_i while no access is outstanding is ignored.
// - READY: cmd_ready_o=1 only here with the engine idle.
//   - valid&ready captures we/addr/wdata; cmd_ready_o drops the following cycle.
//   - The access issues at ISSUE the cycle after capture.
//   - rsp_valid_o pulses on the cycle after the ack. cmd_ready_o returns to 1 on that same cycle.
//   - Latency from accept to rsp_valid_o = 2 + ack latency.
// - ERROR: terminal; init_err_o=1, cmd_ready_o=0, no strobes. Only rst_i exits.
// - init_done_o and init_err_o are never both 1.
// - rst_i mid-access: strobe drops immediately. A late ack after reset release is ignored (engine in DELAY).
// TESTING
// 1. PHY model: ack 3 cycles after stb, ID 24 04 06 00, regs echo writes ->
//    - 4 reads, 3 writes (0x45, 0x00, 0x00), 3 reads;
//    - init_done_o=1, err_code_o=0.
// 2. PHY returns PID low=0x07 -> ERROR after 4th read; init_err_o=1, err_code_o=2; no CFG writes issued.
// 3. PHY never acks the 1st read -> stb once; after 255 cycles init_err_o=1, err_code_o=1.
// 4. PHY stores 0x44 for 0x04 -> readback of 0x04 mismatches; err_code_o=3; no read of 0x07.
// 5. After init, cmd read 0x0A (ack lat 1) -> rsp_valid_o 3 cycles after accept, rsp_rdata_o=0x00, rsp_err_o=0.
//    Then cmd write 0x16=0x5A -> reg_we_o=1, reg_data_o=0x5A.
// 6. Assert rst_i during CFG_WR wait, send ack after release -> outputs 0, DELAY restarts, stray ack ignored, full init passes.

Source files
------------

// File: rtl/ulpi_reg_init.sv
// ULPI PHY register bring-up engine: ID check, config write and readback, then
// single runtime register accesses on behalf of the function controller.
module ulpi_reg_init #(
    parameter logic [15:0] STARTUP_DLY   = 16'd6000,
    parameter logic [7:0]  ACK_TIMEOUT   = 8'd255,
    parameter logic [15:0] VID_EXP       = 16'h0424,
    parameter logic [15:0] PID_EXP       = 16'h0006,
    parameter logic [7:0]  FUNC_CTRL_VAL = 8'h45,
    parameter logic [7:0]  IFC_CTRL_VAL  = 8'h00,
    parameter logic [7:0]  OTG_CTRL_VAL  = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] reg_addr_o,
    output logic       reg_stb_o,
    output logic       reg_we_o,
    output logic [7:0] reg_data_o,
    input  logic [7:0] reg_data_i,
    input  logic       reg_ack_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_we_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       init_done_o,
    output logic       init_err_o,
    output logic [1:0] err_code_o
);

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_ID_RD,
        ST_CFG_WR,
        ST_CFG_RD,
        ST_READY,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ISSUE,
        ACC_WAIT
    } acc_t;

    state_t      state;
    acc_t        acc;
    logic [15:0] dly_cnt;
    logic [7:0]  tmo_cnt;
    logic [1:0]  step;
    logic [23:0] id_sr;
    logic [31:0] id_next;
    logic        id_bad;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_val;
    logic [7:0]  init_addr;
    logic        init_we;

    // Step index selects which configuration register is being written or verified
    always_comb begin
        cfg_addr = 8'h04;
        cfg_val  = FUNC_CTRL_VAL;
        case (step)
            2'd1: begin
                cfg_addr = 8'h07;
                cfg_val  = IFC_CTRL_VAL;
            end
            2'd2: begin
                cfg_addr = 8'h0A;
                cfg_val  = OTG_CTRL_VAL;
            end
            default: ;
        endcase
    end

    assign init_addr = (state == ST_ID_RD) ? {6'd0, step} : cfg_addr;
    assign init_we   = (state == ST_CFG_WR);

    // ID bytes arrive low address first, so the newest byte enters at the top
    assign id_next = {reg_data_i, id_sr};
    assign id_bad  = (id_next[15:0] != VID_EXP) || (id_next[31:16] != PID_EXP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_DELAY;
            acc         <= ACC_IDLE;
            dly_cnt     <= '0;
            tmo_cnt     <= '0;
            step        <= '0;
            id_sr       <= '0;
            reg_addr_o  <= '0;
            reg_stb_o   <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_data_o  <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            init_done_o <= 1'b0;
            init_err_o  <= 1'b0;
            err_code_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (acc != ACC_IDLE) begin
                reg_stb_o <= 1'b0;
                if (reg_ack_i) begin
                    acc <= ACC_IDLE;
                    case (state)
                        ST_ID_RD: begin
                            id_sr <= id_next[31:8];
                            if (step == 2'd3) begin
                                if (id_bad) begin
                                    state      <= ST_ERROR;
                                    init_err_o <= 1'b1;
                                    err_code_o <= 2'd2;
                                end else begin
                                    state <= ST_CFG_WR;
                                    step  <= '0;
                                end
                            end else begin
                                step <= step + 2'd1;
                            end
                        end
                        ST_CFG_WR: begin
                            if (step == 2'd2) begin
                                state <= ST_CFG_RD;
                                step  <= '0;
                            end else begin
                                step <= step + 2'd1;
                            end
                        end
                        ST_CFG_RD: begin
                            if (reg_data_i != cfg_val) begin
                                state      <= ST_ERROR;
                                init_err_o <= 1'b1;
                                err_code_o <= 2'd3;
                            end else if (step == 2'd2) begin
                                state       <= ST_READY;
                                init_done_o <= 1'b1;
                                cmd_ready_o <= 1'b1;
                            end else begin
                                step <= step + 2'd1;
                            end
                        end
                        ST_READY: begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= reg_we_o ? 8'h00 : reg_data_i;
                            cmd_ready_o <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (tmo_cnt == ACK_TIMEOUT - 8'd1) begin
                    // A silent PHY is fatal during bring-up but only reported at runtime
                    acc <= ACC_IDLE;
                    if (state == ST_READY) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= 8'h00;
                        cmd_ready_o <= 1'b1;
                    end else begin
                        state      <= ST_ERROR;
                        init_err_o <= 1'b1;
                        err_code_o <= 2'd1;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    acc     <= ACC_WAIT;
                end
            end else begin
                case (state)
                    ST_DELAY: begin
                        if (dly_cnt == STARTUP_DLY - 16'd1) begin
                            state <= ST_ID_RD;
                            step  <= '0;
                        end else begin
                            dly_cnt <= dly_cnt + 16'd1;
                        end
                    end
                    ST_ID_RD, ST_CFG_WR, ST_CFG_RD: begin
                        acc        <= ACC_ISSUE;
                        tmo_cnt    <= '0;
                        reg_stb_o  <= 1'b1;
                        reg_addr_o <= init_addr;
                        reg_we_o   <= init_we;
                        reg_data_o <= init_we ? cfg_val : 8'h00;
                    end
                    ST_READY: begin
                        if (cmd_valid_i && cmd_ready_o) begin
                            cmd_ready_o <= 1'b0;
                            acc         <= ACC_ISSUE;
                            tmo_cnt     <= '0;
                            reg_stb_o   <= 1'b1;
                            reg_addr_o  <= cmd_addr_i;
                            reg_we_o    <= cmd_we_i;
                            reg_data_o  <= cmd_we_i ? cmd_wdata_i : 8'h00;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
